subckt_response_misr: RTL and testbench



---
 rtl/subckt_obs_pkg.sv | 28 ++
 rtl/misr_core.sv | 37 +++
 rtl/subckt_response_misr.sv | 111 +++++++++++
 tb/tb_subckt_response_misr.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/subckt_obs_pkg.sv
// Shared definitions for the subcircuit response compactor.
//   state_e   : controller states (IDLE, RUN, DONE)
//   DEF_*     : default signature width, window width and MISR feedback mask
//   misr_step : one Galois MISR update at the default width
package subckt_obs_pkg;

  localparam int DEF_SIG_W = 16;
  localparam int DEF_WIN_W = 10;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [DEF_SIG_W-1:0] DEF_POLY = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [DEF_SIG_W-1:0] misr_step(
    input logic [DEF_SIG_W-1:0] sig,
    input logic                 din,
    input logic [DEF_SIG_W-1:0] poly
  );
    logic fb;
    fb = sig[0] ^ din;
    return (sig >> 1) ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/misr_core.sv
// Galois multiple-input signature register, one serial input bit.
//   I1470_clk : clock
//   I1477_rst : asynchronous active-low reset (clears the signature)
//   load      : replace the signature with seed (wins over shift)
//   seed      : value loaded on load
//   shift     : fold din into the signature
//   din       : serial response bit
//   sig       : current signature (registered)
module misr_core
  import subckt_obs_pkg::*;
#(
  parameter int                SIG_W = DEF_SIG_W,
  parameter logic [SIG_W-1:0]  POLY  = DEF_POLY
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             shift,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic fb;
  assign fb = sig[0] ^ din;

  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      sig <= '0;
    end else if (load) begin
      sig <= seed;
    end else if (shift) begin
      sig <= (sig >> 1) ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/subckt_response_misr.sv
// Response compactor: folds a programmable window of qualified 1-bit
// samples into a MISR and offers the signature over valid/ready.
//   I1470_clk, I1477_rst : clock, asynchronous active-low reset
//   start, win_len, seed : window request, accepted only in IDLE
//   obs_in, obs_vld      : observed bit and its qualifier (used in RUN only)
//   busy                 : high in RUN and DONE
//   sig_out, sig_vld     : signature and its valid flag (DONE)
//   sig_rdy              : consumer accept
//   tgl_cnt              : sample transition count, only when the
//                          SUBCKT_MISR_TOGGLE_EN macro is defined
//
// state | meaning
// IDLE  | waiting for start; last signature still visible on sig_out
// RUN   | folding samples, cnt holds samples still to take
// DONE  | signature offered, waiting for sig_rdy
module subckt_response_misr
  import subckt_obs_pkg::*;
#(
  parameter int               SIG_W = DEF_SIG_W,
  parameter int               WIN_W = DEF_WIN_W,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [SIG_W-1:0] seed,
  input  logic             obs_in,
  input  logic             obs_vld,
  output logic             busy,
  output logic [SIG_W-1:0] sig_out,
  output logic             sig_vld,
  input  logic             sig_rdy
`ifdef SUBCKT_MISR_TOGGLE_EN
  ,
  output logic [WIN_W-1:0] tgl_cnt
`endif
);

  state_e           state;
  logic [WIN_W-1:0] cnt;
  logic             accept;
  logic             take;

  assign accept = (state == IDLE) && start;
  assign take   = (state == RUN) && obs_vld;

  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= win_len;
            state <= (win_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (obs_vld) begin
            cnt <= cnt - 1'b1;
            // cnt never reaches 0 inside RUN, so no wrap is possible
            if (cnt == WIN_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (sig_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so no input reaches them
  // combinationally.
  assign busy    = (state != IDLE);
  assign sig_vld = (state == DONE);

  misr_core #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .I1470_clk (I1470_clk),
    .I1477_rst (I1477_rst),
    .load      (accept),
    .seed      (seed),
    .shift     (take),
    .din       (obs_in),
    .sig       (sig_out)
  );

`ifdef SUBCKT_MISR_TOGGLE_EN
  // prev starts each window at 0 so the first sample counts if it is 1
  logic prev;

  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      prev    <= 1'b0;
      tgl_cnt <= '0;
    end else if (accept) begin
      prev    <= 1'b0;
      tgl_cnt <= '0;
    end else if (take) begin
      prev <= obs_in;
      if ((obs_in != prev) && (tgl_cnt != '1)) tgl_cnt <= tgl_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_subckt_response_misr.sv
module tb_subckt_response_misr;

  localparam logic [15:0] POLY = 16'hB400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  win_len = '0;
  logic [15:0] seed = '0;
  logic        obs_in = 1'b0;
  logic        obs_vld = 1'b0;
  logic        sig_rdy = 1'b0;
  logic        busy;
  logic [15:0] sig_out;
  logic        sig_vld;
`ifdef SUBCKT_MISR_TOGGLE_EN
  logic [9:0]  tgl_cnt;
`endif

  always #5 clk = ~clk;

  subckt_response_misr dut (
    .I1470_clk (clk),
    .I1477_rst (rst_n),
    .start     (start),
    .win_len   (win_len),
    .seed      (seed),
    .obs_in    (obs_in),
    .obs_vld   (obs_vld),
    .busy      (busy),
    .sig_out   (sig_out),
    .sig_vld   (sig_vld),
    .sig_rdy   (sig_rdy)
`ifdef SUBCKT_MISR_TOGGLE_EN
    ,
    .tgl_cnt   (tgl_cnt)
`endif
  );

  // Behavioural model: remembers the window's samples and folds them
  // all at once when the window completes.
  logic        m_busy, m_vld;
  int          m_rem;
  logic [15:0] m_seed, m_sig;
  int          m_tgl;
  bit          samples[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_vld = 1'b0; m_rem = 0;
      m_seed = '0;   m_sig = '0;   m_tgl = 0;
      samples.delete();
    end else if (!m_busy) begin
      if (start) begin
        m_seed = seed; m_rem = int'(win_len); samples.delete();
        m_busy = 1'b1; m_tgl = 0;
        if (win_len == 0) begin m_vld = 1'b1; m_sig = seed; end
      end
    end else if (!m_vld) begin
      if (obs_vld) begin
        logic [15:0] s;
        bit p;
        samples.push_back(obs_in);
        m_rem--;
        p = 0; m_tgl = 0;
        foreach (samples[i]) begin
          if (samples[i] != p && m_tgl < 1023) m_tgl++;
          p = samples[i];
        end
        if (m_rem == 0) begin
          s = m_seed;
          foreach (samples[i]) s = (s >> 1) ^ ((s[0] ^ samples[i]) ? POLY : 16'h0);
          m_sig = s;
          m_vld = 1'b1;
        end
      end
    end else if (sig_rdy) begin
      m_busy = 1'b0; m_vld = 1'b0;
    end
  end

  int          n_tests = 0;
  int          n_fail = 0;
  logic        pin_sig_en = 1'b0;
  logic [15:0] pin_sig = '0;
  logic        pin_tgl_en = 1'b0;
  int          pin_tgl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("sig_vld", 32'(sig_vld), 32'(m_vld));
    if (!m_busy || m_vld) chk("sig_out", 32'(sig_out), 32'(m_sig));
    if (pin_sig_en && m_vld) begin
      chk("pin_model_sig", 32'(m_sig), 32'(pin_sig));
      chk("pin_dut_sig", 32'(sig_out), 32'(pin_sig));
    end
`ifdef SUBCKT_MISR_TOGGLE_EN
    chk("tgl_cnt", 32'(tgl_cnt), 32'(m_tgl));
    if (pin_tgl_en && m_vld) chk("pin_tgl", 32'(tgl_cnt), 32'(pin_tgl));
`endif
  end

  // Drive one cycle of inputs, then advance to the next falling edge.
  task automatic step(input logic st, input logic [9:0] wl, input logic [15:0] sd,
                      input logic o, input logic ov, input logic rdy);
    start = st; win_len = wl; seed = sd; obs_in = o; obs_vld = ov; sig_rdy = rdy;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (!m_vld) begin
      step($urandom_range(0, 7) == 0, 10'($urandom), 16'($urandom),
           1'($urandom), $urandom_range(0, 9) < 7, 1'($urandom));
      n++;
      if (n > budget) begin
        $display("FAIL window_timeout: model never completed after %0d cycles", n);
        $fatal(1, "window timeout");
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    // one sample of 1 from seed 0
    pin_sig_en = 1'b1; pin_sig = 16'hB400;
    step(1'b1, 10'd1, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    idle_cycle();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    pin_sig_en = 1'b0;
    idle_cycle();

    // samples 1,0 with a gap
    pin_sig_en = 1'b1; pin_sig = 16'h5A00;
    step(1'b1, 10'd2, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    pin_sig_en = 1'b0;
    idle_cycle();

    // empty window, start pulses during DONE
    pin_sig_en = 1'b1; pin_sig = 16'hACE1;
    step(1'b1, 10'd0, 16'hACE1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'd5, 16'h1111, 1'b1, 1'b1, 1'b0);
    step(1'b1, 10'd3, 16'h2222, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    pin_sig_en = 1'b0;
    idle_cycle();

    // backpressure, then start in the transfer cycle
    step(1'b1, 10'd1, 16'h0F0F, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'd4, 16'h3333, 1'b0, 1'b0, 1'b1);
    idle_cycle();

    // reset mid-RUN after 3 samples
    step(1'b1, 10'd8, 16'h5555, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    pulse_reset();
    idle_cycle();
    step(1'b1, 10'd3, 16'h7777, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle_cycle();

    // toggle pattern 1,1,0,1,0,0
    pin_sig_en = 1'b1; pin_sig = 16'h23E0;
    pin_tgl_en = 1'b1; pin_tgl = 4;
    step(1'b1, 10'd6, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    pin_sig_en = 1'b0; pin_tgl_en = 1'b0;
    idle_cycle();

    // randomized windows
    for (int it = 0; it < 80; it++) begin
      logic [9:0] wl;
      wl = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 3)) : 10'($urandom_range(1, 40));
      step(1'b1, wl, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 9) == 0 && m_busy && !m_vld) begin
        repeat ($urandom_range(0, 2)) step(1'b0, '0, '0, 1'($urandom), 1'b1, 1'b0);
        pulse_reset();
      end else begin
        run_to_done(4000);
        repeat ($urandom_range(0, 4))
          step(1'($urandom), 10'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        step(1'($urandom), 10'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      end
      repeat ($urandom_range(0, 2))
        step(1'b0, '0, '0, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    idle_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
